gold_spawn_gen: RTL and testbench
=================================

// Module: gold_spawn_gen
// PURPOSE
//  Parametrised LFSR spawn generator for the gold_miner playfield: on request, emits N
//  unique (x,y) pixel positions on a COLS x ROWS grid, one per valid/ready handshake.
//  LFSR free-runs every cycle, even when idle. An occupancy bitmap rejects cells already
//  used, so no cell is emitted twice.
//  Sits between the level-setup FSM (start/count) and the object/draw pipeline (x_pos/y_pos).
// PARAMETERS
//  LFSR_W   8      LFSR width; must be >= IDX_W
//  TAPS     8'hB8  Galois feedback mask; must be maximal-length for LFSR_W
//  SEED     8'hFF  LFSR reset value; must be nonzero
//  COLS     8      grid columns; must be a power of 2
//  ROWS     8      grid rows; COLS*ROWS <= 2**LFSR_W - 1
//  X0,DX    2,42   x of column 0, column pitch (pixels)
//  Y0,DY    50,24  y of row 0, row pitch (pixels)
//  X_W,Y_W  9,8    output coordinate widths
//  Derived: CELLS=COLS*ROWS, IDX_W=clog2(CELLS), CNT_W=clog2(CELLS+1)
// PORTS
//  clk        in   1      system clock
//  resetn     in   1      synchronous active-low reset
//  start      in   1      one-cycle request; sampled only in IDLE
//  count      in   CNT_W  positions to emit; sampled with start
//  clear      in   1      clear occupancy bitmap; honoured only in IDLE
//  out_valid  out  1      x_pos/y_pos/cell_idx valid
//  out_ready  in   1      consumer accepts when out_valid & out_ready
//  x_pos      out  X_W    X0 + col*DX, col = idx[log2(COLS)-1:0]
//  y_pos      out  Y_W    Y0 + row*DY, row = idx >> log2(COLS)
//  cell_idx   out  IDX_W  emitted cell index
//  busy       out  1      high in SEARCH and PRESENT
//  done       out  1      one-cycle pulse after the last accept (or on a zero-length request)
//  free_cnt   out  CNT_W  unoccupied cells remaining
// BEHAVIOUR
//  - Clock is clk; reset is synchronous and active-low on resetn.
//  - Reset: lfsr=SEED, bitmap=0, state=IDLE, out_valid=0, busy=0, done=0,
//    x_pos=X0, y_pos=Y0, cell_idx=0, free_cnt=CELLS.
//  - LFSR steps every cycle when resetn is high, Galois form:
//    lfsr <= {1'b0,lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? TAPS : 0).
//    If lfsr ever reads 0, it loads SEED next cycle (lock-up guard).
//  - idx candidate = lfsr[IDX_W-1:0]; rejected if >= CELLS or if its bitmap bit is set.
//  - FSM:
//    - IDLE -> SEARCH on start with eff_cnt != 0.
//      eff_cnt = min(count, free_cnt), latched into the remaining-count register.
//    - IDLE -> IDLE on start with eff_cnt == 0; done pulses the next cycle.
//    - SEARCH: each cycle, test the candidate. On accept: set the bitmap bit,
//      decrement free_cnt, register x/y/idx, go to PRESENT (out_valid=1 next cycle).
//      Latency from start to first out_valid is >= 2 cycles; it is unbounded only by
//      the LFSR period, which guarantees a hit within 2**LFSR_W-1 cycles.
//    - PRESENT: outputs are held stable while out_valid & !out_ready.
//      On handshake, decrement the remaining count; if it reaches 0, go to IDLE and
//      pulse done next cycle; else go to SEARCH (out_valid drops for >= 1 cycle).
//  - start during busy: ignored. clear during busy: ignored.
//    clear and start in the same IDLE cycle: clear applies first; free_cnt=CELLS
//    is used for eff_cnt.
//  - Synchronous reset mid-operation aborts immediately to the reset values above;
//    no done pulse.
//  - Arithmetic: x/y products computed at X_W/Y_W width; overflow is a parameter
//    error, not handled.
//  - The bitmap persists across requests, so successive levels never reuse a cell
//    until clear.
// CONFIGURATION
//  - SPAWN_SEED_LOAD_EN defined: adds ports seed_load (in, 1) and seed (in, LFSR_W).
//    A seed_load in any state loads lfsr=seed next cycle; if seed==0, SEED is loaded.
//    This allows a user-entropy reseed (e.g. from a keypress timestamp).
//  - SPAWN_SEED_LOAD_EN undefined: no such ports; the LFSR is reseeded only by reset.
// TESTING
//  - Reset, then 300 cycles idle: outputs hold reset values; lfsr visits all 255 nonzero
//    states before repeating SEED.
//  - start, count=64, out_ready=1: exactly 64 accepts, 64 distinct cell_idx, free_cnt=0,
//    one done pulse.
//  - start, count=10, out_ready=0 for 5 cycles after out_valid: x_pos/y_pos/cell_idx
//    stable; then accept resumes.
//  - After the 64-cell fill: start, count=3 -> done pulse only, no out_valid.
//    clear, then start count=3 -> 3 outputs.
//  - Coordinate check: every output satisfies x=2+42*(idx%8), y=50+24*(idx/8);
//    idx 63 -> (296,218).
//  - resetn low mid-PRESENT: next cycle out_valid=0, busy=0, free_cnt=64, no done.
//    Under SPAWN_SEED_LOAD_EN: seed_load with seed=0 -> lfsr=8'hFF.

Source files
------------

// File: rtl/gold_spawn_if.sv
// Request/stream bundle between the level-setup FSM, the spawn generator and the draw pipeline.
// Handshake: a position transfers on any clk edge where out_valid & out_ready; while out_valid is high and out_ready low, x_pos/y_pos/cell_idx hold.
interface gold_spawn_if #(
  parameter int CNT_W = 7,
  parameter int IDX_W = 6,
  parameter int X_W   = 9,
  parameter int Y_W   = 8
);
  logic             start;
  logic [CNT_W-1:0] count;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [X_W-1:0]   x_pos;
  logic [Y_W-1:0]   y_pos;
  logic [IDX_W-1:0] cell_idx;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] free_cnt;

  modport master (
    input  start, count, clear, out_ready,
    output out_valid, x_pos, y_pos, cell_idx, busy, done, free_cnt
  );

  modport slave (
    output start, count, clear, out_ready,
    input  out_valid, x_pos, y_pos, cell_idx, busy, done, free_cnt
  );
endinterface

// File: rtl/gold_spawn_gen.sv
// LFSR spawn generator: emits unique (x,y) grid positions from a free-running Galois LFSR.
// Optional SPAWN_SEED_LOAD_EN adds seed_load/seed ports for a runtime reseed.
module gold_spawn_gen #(
  parameter int                LFSR_W = 8,
  parameter logic [LFSR_W-1:0] TAPS   = 8'hB8,
  parameter logic [LFSR_W-1:0] SEED   = 8'hFF,
  parameter int                COLS   = 8,
  parameter int                ROWS   = 8,
  parameter int                X0     = 2,
  parameter int                DX     = 42,
  parameter int                Y0     = 50,
  parameter int                DY     = 24,
  parameter int                X_W    = 9,
  parameter int                Y_W    = 8,
  localparam int               CELLS  = COLS * ROWS,
  localparam int               IDX_W  = $clog2(CELLS),
  localparam int               CNT_W  = $clog2(CELLS + 1)
) (
  input  logic              clk,
  input  logic              resetn,
`ifdef SPAWN_SEED_LOAD_EN
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
`endif
  gold_spawn_if.master      bus,
  output logic [1:0]        dbg_state_o,
  output logic [LFSR_W-1:0] dbg_lfsr_o
);

  localparam int               COL_B   = $clog2(COLS);
  localparam logic [CNT_W-1:0] CELLS_C = CNT_W'(CELLS);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_PRESENT} state_e;

  state_e             state_q, state_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [CELLS-1:0]   bitmap_q, bitmap_d;
  logic [CNT_W-1:0]   free_q, free_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               done_q, done_d;

  logic [IDX_W-1:0]   cand, cand_col, cand_row;
  logic               cand_ok;
  logic [X_W-1:0]     cand_x;
  logic [Y_W-1:0]     cand_y;
  logic [CNT_W-1:0]   avail_cnt, eff_cnt;

  // Free-running Galois step; an all-zero state would lock up, so it reloads SEED.
  always_comb begin
    lfsr_d = (lfsr_q == '0) ? SEED
           : ({1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? TAPS : '0));
`ifdef SPAWN_SEED_LOAD_EN
    if (seed_load) lfsr_d = (seed == '0) ? SEED : seed;
`endif
  end

  always_comb begin
    cand      = lfsr_q[IDX_W-1:0];
    cand_col  = cand & IDX_W'(COLS - 1);
    cand_row  = cand >> COL_B;
    cand_ok   = (CNT_W'(cand) < CELLS_C) && !bitmap_q[cand];
    cand_x    = X_W'(X0) + X_W'(cand_col) * X_W'(DX);
    cand_y    = Y_W'(Y0) + Y_W'(cand_row) * Y_W'(DY);
    // A same-cycle clear empties the grid before the request is sized.
    avail_cnt = bus.clear ? CELLS_C : free_q;
    eff_cnt   = (bus.count < avail_cnt) ? bus.count : avail_cnt;
  end

  always_comb begin
    state_d  = state_q;
    bitmap_d = bitmap_q;
    free_d   = free_q;
    rem_d    = rem_q;
    x_d      = x_q;
    y_d      = y_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.clear) begin
          bitmap_d = '0;
          free_d   = CELLS_C;
        end
        if (bus.start) begin
          if (eff_cnt != '0) begin
            rem_d   = eff_cnt;
            state_d = S_SEARCH;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      S_SEARCH: begin
        if (cand_ok) begin
          bitmap_d[cand] = 1'b1;
          free_d         = free_q - CNT_W'(1);
          x_d            = cand_x;
          y_d            = cand_y;
          idx_d          = cand;
          state_d        = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (bus.out_ready) begin
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_SEARCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      lfsr_q   <= SEED;
      bitmap_q <= '0;
      free_q   <= CELLS_C;
      rem_q    <= '0;
      x_q      <= X_W'(X0);
      y_q      <= Y_W'(Y0);
      idx_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      bitmap_q <= bitmap_d;
      free_q   <= free_d;
      rem_q    <= rem_d;
      x_q      <= x_d;
      y_q      <= y_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
    end
  end

  assign bus.out_valid = (state_q == S_PRESENT);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.x_pos     = x_q;
  assign bus.y_pos     = y_q;
  assign bus.cell_idx  = idx_q;
  assign bus.free_cnt  = free_q;
  assign dbg_state_o   = state_q;
  assign dbg_lfsr_o    = lfsr_q;

endmodule

// File: tb/tb_gold_spawn_gen.sv
// Directed bench for gold_spawn_gen: request table plus hand-written reset/stall/LFSR sequences.
module tb_gold_spawn_gen;

  localparam int CNT_W = 7;
  localparam int IDX_W = 6;
  localparam int X_W   = 9;
  localparam int Y_W   = 8;
  localparam int BUDGET = 20000;

  // Clock / reset
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  gold_spawn_if #(.CNT_W(CNT_W), .IDX_W(IDX_W), .X_W(X_W), .Y_W(Y_W)) bus ();
  logic [1:0] dbg_state;
  logic [7:0] dbg_lfsr;
`ifdef SPAWN_SEED_LOAD_EN
  logic       seed_load = 1'b0;
  logic [7:0] seed = 8'h00;
`endif

  gold_spawn_gen dut (
    .clk         (clk),
    .resetn      (resetn),
`ifdef SPAWN_SEED_LOAD_EN
    .seed_load   (seed_load),
    .seed        (seed),
`endif
    .bus         (bus),
    .dbg_state_o (dbg_state),
    .dbg_lfsr_o  (dbg_lfsr)
  );

  typedef struct {
    logic clr;
    int   cnt;
    logic stall;
    int   exp_outs;
    int   exp_free;
  } req_t;

  int n_cmp = 0;
  int n_bad = 0;
  logic [X_W+Y_W+IDX_W-1:0] exp_q[$];
  bit used[64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    if (v == 8'h00) return 8'hFF;
    return {1'b0, v[7:1]} ^ (v[0] ? 8'hB8 : 8'h00);
  endfunction

  // Driver: issue one request, consume its stream, score it.
  task automatic run_req(input req_t r);
    int outs = 0, dones = 0, first_v = -1, cyc = 0, extra_v = 0;
    logic [IDX_W-1:0] idx;
    int ex, ey;
    if (r.clr) for (int i = 0; i < 64; i++) used[i] = 1'b0;
    bus.out_ready = r.stall ? 1'b0 : 1'b1;
    bus.clear = r.clr;
    bus.count = CNT_W'(r.cnt);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.clear = 1'b0;
    cyc = 1;
    while (cyc < BUDGET) begin
      if (bus.done) begin
        dones++;
        break;
      end
      if (bus.out_valid) begin
        if (first_v < 0) first_v = cyc;
        idx = bus.cell_idx;
        ex = 2 + 42 * (int'(idx) % 8);
        ey = 50 + 24 * (int'(idx) / 8);
        check("x_pos", bus.x_pos, ex);
        check("y_pos", bus.y_pos, ey);
        check("unique_idx", used[idx], 0);
        check("busy_present", bus.busy, 1);
        used[idx] = 1'b1;
        outs++;
        if (r.stall) begin
          exp_q.push_back({bus.x_pos, bus.y_pos, bus.cell_idx});
          repeat (5) begin
            step(); cyc++;
            check("stall_hold", {bus.x_pos, bus.y_pos, bus.cell_idx}, exp_q[0]);
            check("stall_valid", bus.out_valid, 1);
          end
          void'(exp_q.pop_front());
          bus.out_ready = 1'b1;
          step(); cyc++;
          bus.out_ready = 1'b0;
        end else begin
          step(); cyc++;
        end
      end else begin
        step(); cyc++;
      end
    end
    repeat (3) begin
      step();
      if (bus.done) dones++;
      if (bus.out_valid) extra_v++;
    end
    check("done_pulses", dones, 1);
    check("outputs", outs, r.exp_outs);
    check("free_cnt", bus.free_cnt, r.exp_free);
    check("valid_after_done", extra_v, 0);
    check("busy_after_done", bus.busy, 0);
    if (r.exp_outs > 0) check("first_latency_ge2", (first_v >= 2), 1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    req_t tbl[7];
    int lfsr_bad = 0, idle_bad = 0, period = 0, distinct = 0, got_v = 0;
    logic [7:0] exp_l;
    bit seen[256];

    tbl[0] = '{1'b0, 0,   1'b0, 0,  64};
    tbl[1] = '{1'b0, 10,  1'b1, 10, 54};
    tbl[2] = '{1'b1, 64,  1'b0, 64, 0};
    tbl[3] = '{1'b0, 3,   1'b0, 0,  0};
    tbl[4] = '{1'b1, 3,   1'b0, 3,  61};
    tbl[5] = '{1'b0, 100, 1'b0, 61, 0};
    tbl[6] = '{1'b1, 0,   1'b0, 0,  64};

    bus.start = 1'b0;
    bus.count = '0;
    bus.clear = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 64; i++) used[i] = 1'b0;

    repeat (3) step();
    check("rst_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_x", bus.x_pos, 2);
    check("rst_y", bus.y_pos, 50);
    check("rst_idx", bus.cell_idx, 0);
    check("rst_free", bus.free_cnt, 64);
    check("rst_lfsr", dbg_lfsr, 8'hFF);
    check("rst_state", dbg_state, 0);

    // 300 idle cycles: outputs hold, LFSR walks its full period.
    resetn = 1'b1;
    exp_l = 8'hFF;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (dbg_lfsr !== exp_l) lfsr_bad++;
      if (i < 255 && !seen[dbg_lfsr]) begin
        seen[dbg_lfsr] = 1'b1;
        distinct++;
      end
      if (i > 0 && dbg_lfsr == 8'hFF && period == 0) period = i;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
          bus.x_pos !== 9'd2 || bus.y_pos !== 8'd50 || bus.cell_idx !== 6'd0 ||
          bus.free_cnt !== 7'd64) idle_bad++;
      exp_l = lfsr_step(exp_l);
      step();
    end
    check("lfsr_sequence", lfsr_bad, 0);
    check("lfsr_period", period, 255);
    check("lfsr_distinct", distinct, 255);
    check("idle_hold", idle_bad, 0);

    for (int t = 0; t < 7; t++) begin
      repeat ($urandom_range(0, 3)) step();
      run_req(tbl[t]);
    end

    // Reset while a position is presented: abort with no done pulse.
    bus.clear = 1'b1;
    bus.count = CNT_W'(5);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.clear = 1'b0;
    for (int i = 0; i < 1000 && !got_v; i++) begin
      if (bus.out_valid) got_v = 1;
      else step();
    end
    check("mid_valid_seen", got_v, 1);
    check("mid_free_before", bus.free_cnt, 63);
    resetn = 1'b0;
    step();
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_free", bus.free_cnt, 64);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_lfsr", dbg_lfsr, 8'hFF);
    resetn = 1'b1;
    step();
    check("post_rst_done", bus.done, 0);
    check("post_rst_valid", bus.out_valid, 0);

`ifdef SPAWN_SEED_LOAD_EN
    seed_load = 1'b1;
    seed = 8'h00;
    step();
    check("seed_zero", dbg_lfsr, 8'hFF);
    seed = 8'h5A;
    step();
    check("seed_5a", dbg_lfsr, 8'h5A);
    seed_load = 1'b0;
    step();
    check("seed_step", dbg_lfsr, lfsr_step(8'h5A));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
